invaders_input_ctrl: RTL



---
 rtl/invaders_input_pkg.sv | 31 +++
 rtl/invaders_coin_seq.sv | 94 +++++++++
 rtl/invaders_input_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/invaders_input_pkg.sv
// invaders_input_pkg
//   Shared constants for the Invaders input front end.
//   - PS/2 set-2 scancodes for the keys the game uses
//   - joystick word bit positions (as delivered by hps_io)
//   - coin sequencer state encoding
package invaders_input_pkg;

  // Full 9-bit codes: bit 8 is the extended (E0) prefix flag.
  localparam logic [8:0] KC_FIRE    = 9'h029;  // space
  localparam logic [8:0] KC_START1  = 9'h005;  // F1
  localparam logic [8:0] KC_START2  = 9'h006;  // F2
  localparam logic [8:0] KC_COIN    = 9'h004;  // F3

  // Arrow keys share the low byte with keypad keys; bit 8 is ignored.
  localparam logic [7:0] KC_LEFT_LO  = 8'h6B;
  localparam logic [7:0] KC_RIGHT_LO = 8'h74;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_FIRE   = 4;
  localparam int JB_START1 = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

endpackage

// File: rtl/invaders_coin_seq.sv
// invaders_coin_seq
//   Queues coin requests (saturating at 3) and plays them out as timed
//   btn_coin pulses separated by a low gap.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no pulse in flight; consumes one pending coin if any
//   PULSE | btn_coin high, counting COIN_PULSE_CYC cycles
//   GAP   | btn_coin low, counting COIN_GAP_CYC cycles before next coin
//
// Ports:
//   clk_sys, reset  clock, asynchronous active-high reset
//   req             one-cycle coin request strobe
//   btn_coin        registered coin pulse to the game
//   coin_pending    queued coins not yet pulsed (0..3)
//   start_block     high while a coin is queued, in flight or requested now
module invaders_coin_seq
  import invaders_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 2000000,
  parameter int COIN_GAP_CYC   = 2000000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       req,
  output logic       btn_coin,
  output logic [1:0] coin_pending,
  output logic       start_block
);

  localparam int MAX_CYC = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(COIN_GAP_CYC - 1);

  coin_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic          consume;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 2'd0) begin
          consume = 1'b1;
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A request landing on the consume cycle simply replaces the coin taken.
    pend_d = pend_q;
    if (req && !consume) begin
      if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
    end else if (!req && consume) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 2'd0;
      btn_coin <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      btn_coin <= (state_d == PULSE);
    end
  end

  assign coin_pending = pend_q;
  assign start_block  = (state_q != IDLE) | (pend_q != 2'd0) | req;

endmodule

// File: rtl/invaders_input_ctrl.sv
// invaders_input_ctrl
//   Input conditioner between hps_io and invaders_top: decodes PS/2 key
//   events into held key states, merges them with the joystick, turns coin
//   and start presses into queued coin pulses, and holds start off until
//   the coin has been delivered.
//
//   Build option: define INVADERS_AUTOFIRE_EN to make a held fire button
//   produce a square wave of half-period AUTOFIRE_HALF cycles.
//
// Ports:
//   clk_sys, reset   clock, asynchronous active-high reset
//   ps2_key[10:0]    [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joy[15:0]        OR of both joysticks
//   btn_fire/left/right       registered merged levels
//   btn_one_player/two_player registered starts, gated by the coin sequence
//   btn_coin         timed coin pulse
//   coin_pending     queued coins (0..3)
module invaders_input_ctrl
  import invaders_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 2000000,
  parameter int COIN_GAP_CYC   = 2000000,
  parameter int START_COIN     = 1,
  parameter int AUTOFIRE_HALF  = 800000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  output logic        btn_fire,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_one_player,
  output logic        btn_two_player,
  output logic        btn_coin,
  output logic [1:0]  coin_pending
);

  logic prev_tog, primed, ps2_event;
  logic key_fire, key_left, key_right, key_start1, key_start2, key_coin;
  logic lvl_fire, lvl_left, lvl_right, lvl_start1, lvl_start2, lvl_coin;
  logic lvl_start1_q, lvl_start2_q, lvl_coin_q;
  logic start_rise, coin_req, start_block;
  logic unused_joy;

  assign unused_joy = ^{joy[15:8], joy[3:2]};

  // The first cycle after reset only samples the toggle, so a stale
  // toggle level from hps_io is not mistaken for a fresh event.
  assign ps2_event = primed & (ps2_key[10] ^ prev_tog);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_tog   <= 1'b0;
      primed     <= 1'b0;
      key_fire   <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin   <= 1'b0;
    end else begin
      prev_tog <= ps2_key[10];
      primed   <= 1'b1;
      if (ps2_event) begin
        if (ps2_key[8:0] == KC_FIRE)     key_fire   <= ps2_key[9];
        if (ps2_key[8:0] == KC_START1)   key_start1 <= ps2_key[9];
        if (ps2_key[8:0] == KC_START2)   key_start2 <= ps2_key[9];
        if (ps2_key[8:0] == KC_COIN)     key_coin   <= ps2_key[9];
        if (ps2_key[7:0] == KC_LEFT_LO)  key_left   <= ps2_key[9];
        if (ps2_key[7:0] == KC_RIGHT_LO) key_right  <= ps2_key[9];
      end
    end
  end

  assign lvl_fire   = key_fire   | joy[JB_FIRE];
  assign lvl_left   = key_left   | joy[JB_LEFT];
  assign lvl_right  = key_right  | joy[JB_RIGHT];
  assign lvl_start1 = key_start1 | joy[JB_START1];
  assign lvl_start2 = key_start2 | joy[JB_START2];
  assign lvl_coin   = key_coin   | joy[JB_COIN];

  assign start_rise = (lvl_start1 & ~lvl_start1_q) | (lvl_start2 & ~lvl_start2_q);
  assign coin_req   = (lvl_coin & ~lvl_coin_q) | ((START_COIN != 0) & start_rise);

  invaders_coin_seq #(
    .COIN_PULSE_CYC (COIN_PULSE_CYC),
    .COIN_GAP_CYC   (COIN_GAP_CYC)
  ) u_coin_seq (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req          (coin_req),
    .btn_coin     (btn_coin),
    .coin_pending (coin_pending),
    .start_block  (start_block)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lvl_start1_q   <= 1'b0;
      lvl_start2_q   <= 1'b0;
      lvl_coin_q     <= 1'b0;
      btn_left       <= 1'b0;
      btn_right      <= 1'b0;
      btn_one_player <= 1'b0;
      btn_two_player <= 1'b0;
    end else begin
      lvl_start1_q   <= lvl_start1;
      lvl_start2_q   <= lvl_start2;
      lvl_coin_q     <= lvl_coin;
      btn_left       <= lvl_left;
      btn_right      <= lvl_right;
      btn_one_player <= lvl_start1 & ~start_block;
      btn_two_player <= lvl_start2 & ~start_block;
    end
  end

`ifdef INVADERS_AUTOFIRE_EN
  localparam int AF_CW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
  localparam logic [AF_CW-1:0] AF_LAST = AF_CW'(AUTOFIRE_HALF - 1);

  logic [AF_CW-1:0] af_cnt;
  logic             af_phase;  // level btn_fire takes on the next held cycle

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      btn_fire <= 1'b0;
    end else if (!lvl_fire) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      btn_fire <= 1'b0;
    end else begin
      btn_fire <= af_phase;
      if (af_cnt == AF_LAST) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + AF_CW'(1);
      end
    end
  end
`else
  localparam int unused_autofire_half = AUTOFIRE_HALF;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) btn_fire <= 1'b0;
    else       btn_fire <= lvl_fire;
  end
`endif

endmodule
